ic2_arbiter: RTL and testbench
==============================

IC2_ARBITER -- requirements
Module: ic2_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- HOLD_CYCLES, 4, CLK cycles START_STB is held high (must cover one full SCL period of CLK/4); legal 1..15.
- TXN_CYCLES, 128, CLK cycles waited after START_STB drops before the transaction is complete; legal 1..255.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- CLK  in  1  single clock; all logic on posedge CLK.
- RESET  in  1  synchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has a transaction pending; held with fields until REQ0_READY.
- REQ0_RNW  in  1  1 = read, 0 = write.
- REQ0_ADDR  in  7  target 7-bit address.
- REQ0_WDATA  in  16  write data.
- REQ0_READY  out  1  one-cycle accept pulse.
- REQ0_DONE  out  1  one-cycle completion pulse.
- REQ0_RDATA  out  16  last read data returned to requester 0.
- REQ1_VALID, REQ1_RNW, REQ1_ADDR, REQ1_WDATA, REQ1_READY, REQ1_DONE, REQ1_RDATA: same as REQ0_*, for requester 1.
- START_STB  out  1  transaction start strobe to the I2C master.
- RNW  out  1  forwarded RNW of the granted request.
- IC2_ADDR  out  7  forwarded address.
- WR_DATA  out  16  forwarded write data.
- RD_DATA  in  16  read data from the I2C master.
- BUSY  out  1  a transaction is in progress.

Function
REQ-003 The block SHALL implement the FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs SHALL be registered.
REQ-004 In IDLE, at the posedge of cycle T with any REQn_VALID=1, the block SHALL grant one requester:
- if only one requester is valid, it is granted;
- if both are valid, the one not granted last is granted (round-robin pointer).
REQ-005 The grant at cycle T SHALL:
- latch that requester's RNW, ADDR and WDATA;
- pulse REQn_READY high for exactly cycle T+1;
- enter ISSUE in cycle T+1;
- update the round-robin pointer.
REQ-006 In ISSUE, START_STB SHALL be high for cycles T+1 .. T+HOLD_CYCLES, then low. The FSM SHALL then enter WAIT.
REQ-007 WAIT SHALL last exactly TXN_CYCLES cycles, counted by an 8-bit down-counter, then enter DONE.
REQ-008 DONE SHALL last exactly 1 cycle:
- REQn_DONE for the granted requester is high in that cycle only;
- if the latched RNW=1, REQn_RDATA takes RD_DATA (sampled at the WAIT->DONE edge) in that same cycle.
REQ-009 A write (RNW=0) SHALL leave REQn_RDATA unchanged. REQn_RDATA SHALL hold its value until the next completed read of the same requester.
REQ-010 RNW, IC2_ADDR and WR_DATA SHALL be stable from T+1 through the DONE cycle, and SHALL retain their last values while IDLE.
REQ-011 BUSY SHALL be high from T+1 through the DONE cycle inclusive, and low in IDLE.
REQ-012 The earliest next grant SHALL be sampled in the IDLE cycle following DONE; back-to-back spacing is HOLD_CYCLES+TXN_CYCLES+2 cycles.
REQ-013 VALID changes or field changes on any requester after its READY, or on the non-granted requester during a transaction, SHALL have no effect on the current transaction.
REQ-014 A VALID that drops before its grant SHALL be treated as never issued.
REQ-015 At most one REQn_READY and at most one REQn_DONE SHALL be high in any cycle.

Reset
REQ-016 With RESET=1 at a posedge, the next cycle SHALL show:
- FSM in IDLE, all outputs 0, RDATA registers 0, counters 0;
- round-robin pointer set so that REQ0 wins the first contention.
REQ-017 RESET asserted in ISSUE, WAIT or DONE SHALL abort the transaction with no DONE pulse and no RDATA update; START_STB SHALL be 0 the next cycle.

Verification (HOLD_CYCLES=4, TXN_CYCLES=16)
REQ-018 Single write: REQ0_VALID=1, RNW=0, ADDR=7'h50, WDATA=16'hA5C3 at cycle 0 ->
- REQ0_READY at cycle 1;
- START_STB at cycles 1-4, IC2_ADDR=7'h50, WR_DATA=16'hA5C3;
- REQ0_DONE at cycle 21; REQ0_RDATA stays 0.
REQ-019 Single read: REQ1 read, ADDR=7'h3C, RD_DATA driven 16'hBEEF ->
- REQ1_DONE at cycle 21 and REQ1_RDATA=16'hBEEF in the same cycle;
- REQ0_RDATA unchanged.
REQ-020 Contention after reset: both VALID at cycle 0 -> REQ0 granted first; REQ1 granted at the next IDLE (READY at cycle 23).
REQ-021 Round-robin: both VALID held continuously -> grants alternate 0,1,0,1 over 4 transactions, one every 22 cycles.
REQ-022 Reset mid-WAIT: RESET=1 at cycle 10 of a read ->
- no DONE pulse, RDATA unchanged (0), BUSY=0 at cycle 11;
- a new request at cycle 12 is accepted normally.
REQ-023 Field change after accept: REQ0_ADDR changed from 7'h50 to 7'h51 at cycle 2 -> IC2_ADDR stays 7'h50 through DONE.

Source files
------------

// File: rtl/ic2_arbiter.sv
// ic2_arbiter: two-requester round-robin front end for a single I2C master.
// A grant latches the winner's fields, strobes START_STB for HOLD_CYCLES,
// waits TXN_CYCLES for the master to finish, then pulses DONE (and captures
// RD_DATA for reads) before returning to IDLE. Every output is a flop.
module ic2_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int TXN_CYCLES  = 128
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ0_VALID,
  input  logic        REQ0_RNW,
  input  logic [6:0]  REQ0_ADDR,
  input  logic [15:0] REQ0_WDATA,
  output logic        REQ0_READY,
  output logic        REQ0_DONE,
  output logic [15:0] REQ0_RDATA,
  input  logic        REQ1_VALID,
  input  logic        REQ1_RNW,
  input  logic [6:0]  REQ1_ADDR,
  input  logic [15:0] REQ1_WDATA,
  output logic        REQ1_READY,
  output logic        REQ1_DONE,
  output logic [15:0] REQ1_RDATA,
  output logic        START_STB,
  output logic        RNW,
  output logic [6:0]  IC2_ADDR,
  output logic [15:0] WR_DATA,
  input  logic [15:0] RD_DATA,
  output logic        BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TXN_LOAD  = 8'(TXN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ptr_q, ptr_d;     // requester granted last
  logic             gnt_q, gnt_d;     // requester owning the current transaction
  logic [1:0]       ready_q, ready_d;
  logic [1:0]       done_q, done_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             rnw_q, rnw_d;
  logic [6:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [1:0][15:0] rdata_q, rdata_d;

  logic             any_vld;
  logic             win;

  // Winner selection: lone requester wins, contention goes to the one not served last.
  always_comb begin
    any_vld = REQ0_VALID | REQ1_VALID;
    win     = 1'b0;
    if (REQ0_VALID && REQ1_VALID) win = ~ptr_q;
    else if (REQ1_VALID)          win = 1'b1;
  end

  // Next-state and registered-output logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ready_d = '0;
    done_d  = '0;
    start_d = 1'b0;
    busy_d  = busy_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (any_vld) begin
          gnt_d        = win;
          ptr_d        = win;
          ready_d[win] = 1'b1;
          rnw_d        = win ? REQ1_RNW   : REQ0_RNW;
          addr_d       = win ? REQ1_ADDR  : REQ0_ADDR;
          wdata_d      = win ? REQ1_WDATA : REQ0_WDATA;
          start_d      = 1'b1;
          busy_d       = 1'b1;
          cnt_d        = HOLD_LOAD;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = TXN_LOAD;
          state_d = S_WAIT;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          start_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          done_d[gnt_q] = 1'b1;
          if (rnw_q) rdata_d[gnt_q] = RD_DATA;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction and biases the pointer toward REQ0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ptr_q   <= 1'b1;
      gnt_q   <= 1'b0;
      ready_q <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign REQ0_READY = ready_q[0];
  assign REQ1_READY = ready_q[1];
  assign REQ0_DONE  = done_q[0];
  assign REQ1_DONE  = done_q[1];
  assign REQ0_RDATA = rdata_q[0];
  assign REQ1_RDATA = rdata_q[1];
  assign START_STB  = start_q;
  assign RNW        = rnw_q;
  assign IC2_ADDR   = addr_q;
  assign WR_DATA    = wdata_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_ic2_arbiter.sv
// tb_ic2_arbiter: directed vector table, hand-written corner sequences and a
// randomized run, all checked every cycle against a timestamp-based model.
module tb_ic2_arbiter;
  localparam int H = 4;
  localparam int T = 16;
  localparam int DONE_OFS = H + T + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v0 = 0, rnw0 = 0, v1 = 0, rnw1 = 0;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic [15:0] wd0 = '0, wd1 = '0, rd_data = '0;
  logic ready0, done0, ready1, done1, start, rnw, busy;
  logic [15:0] rdata0, rdata1, wr_data;
  logic [6:0] ic2_addr;

  ic2_arbiter #(.HOLD_CYCLES(H), .TXN_CYCLES(T)) dut (
    .CLK(clk), .RESET(rst),
    .REQ0_VALID(v0), .REQ0_RNW(rnw0), .REQ0_ADDR(addr0), .REQ0_WDATA(wd0),
    .REQ0_READY(ready0), .REQ0_DONE(done0), .REQ0_RDATA(rdata0),
    .REQ1_VALID(v1), .REQ1_RNW(rnw1), .REQ1_ADDR(addr1), .REQ1_WDATA(wd1),
    .REQ1_READY(ready1), .REQ1_DONE(done1), .REQ1_RDATA(rdata1),
    .START_STB(start), .RNW(rnw), .IC2_ADDR(ic2_addr), .WR_DATA(wr_data),
    .RD_DATA(rd_data), .BUSY(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int c = 0;

  // Reference model: a transaction is a start timestamp plus latched fields.
  bit          m_active = 0;
  int          m_t0 = 0, m_g = 0, m_last = 1;
  logic        m_rnw = 0;
  logic [6:0]  m_addr = '0;
  logic [15:0] m_wd = '0;
  logic [15:0] m_rd [2] = '{16'h0, 16'h0};
  logic e_ready0, e_ready1, e_done0, e_done1, e_start, e_busy;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s @cyc %0d: got %h want %h", nm, c, act, exp);
    end
  endfunction

  function automatic void model_step();
    int n;
    bit idle;
    if (rst) begin
      m_active = 0; m_last = 1; m_rnw = 0; m_addr = '0; m_wd = '0;
      m_rd[0] = '0; m_rd[1] = '0;
    end else begin
      if (m_active && (c + 1 == m_t0 + DONE_OFS) && m_rnw) m_rd[m_g] = rd_data;
      idle = !m_active || (c >= m_t0 + DONE_OFS + 1);
      if (idle && (v0 || v1)) begin
        if (v0 && v1) m_g = 1 - m_last;
        else          m_g = v1 ? 1 : 0;
        m_last = m_g; m_t0 = c; m_active = 1;
        m_rnw  = m_g ? rnw1  : rnw0;
        m_addr = m_g ? addr1 : addr0;
        m_wd   = m_g ? wd1   : wd0;
      end
    end
    n = c + 1;
    e_ready0 = m_active && n == m_t0 + 1 && m_g == 0;
    e_ready1 = m_active && n == m_t0 + 1 && m_g == 1;
    e_done0  = m_active && n == m_t0 + DONE_OFS && m_g == 0;
    e_done1  = m_active && n == m_t0 + DONE_OFS && m_g == 1;
    e_start  = m_active && n >= m_t0 + 1 && n <= m_t0 + H;
    e_busy   = m_active && n >= m_t0 + 1 && n <= m_t0 + DONE_OFS;
  endfunction

  function automatic void check_all();
    chk("ready0", 32'(ready0), 32'(e_ready0));
    chk("ready1", 32'(ready1), 32'(e_ready1));
    chk("done0",  32'(done0),  32'(e_done0));
    chk("done1",  32'(done1),  32'(e_done1));
    chk("start",  32'(start),  32'(e_start));
    chk("busy",   32'(busy),   32'(e_busy));
    chk("rnw",    32'(rnw),    32'(m_rnw));
    chk("addr",   32'(ic2_addr), 32'(m_addr));
    chk("wdata",  32'(wr_data),  32'(m_wd));
    chk("rdata0", 32'(rdata0), 32'(m_rd[0]));
    chk("rdata1", 32'(rdata1), 32'(m_rd[1]));
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    c++;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  typedef struct {
    bit          who;
    logic        rnw;
    logic [6:0]  addr;
    logic [15:0] wd;
    logic [15:0] rd;
    int          exp_ready;
    int          exp_done;
    logic [15:0] exp_rd0;
    logic [15:0] exp_rd1;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input vec_t v);
    int rdy = -1, dn = -1, st_first = -1, st_cnt = 0;
    logic [15:0] r0 = 'x, r1 = 'x, wd_dn = 'x;
    logic [6:0] a_dn = 'x;
    if (!v.who) begin v0 = 1; rnw0 = v.rnw; addr0 = v.addr; wd0 = v.wd; end
    else        begin v1 = 1; rnw1 = v.rnw; addr1 = v.addr; wd1 = v.wd; end
    rd_data = v.rd;
    for (int k = 1; k <= 40 && dn < 0; k++) begin
      tick();
      if ((v.who ? ready1 : ready0) === 1'b1) begin rdy = k; v0 = 0; v1 = 0; end
      if (start === 1'b1) begin if (st_first < 0) st_first = k; st_cnt++; end
      if ((v.who ? done1 : done0) === 1'b1) begin
        dn = k; r0 = rdata0; r1 = rdata1; a_dn = ic2_addr; wd_dn = wr_data;
      end
    end
    chk("vec_ready_cyc", 32'(rdy), 32'(v.exp_ready));
    chk("vec_start_first", 32'(st_first), 32'd1);
    chk("vec_start_len", 32'(st_cnt), 32'(H));
    chk("vec_done_cyc", 32'(dn), 32'(v.exp_done));
    chk("vec_rdata0", 32'(r0), 32'(v.exp_rd0));
    chk("vec_rdata1", 32'(r1), 32'(v.exp_rd1));
    chk("vec_addr_at_done", 32'(a_dn), 32'(v.addr));
    chk("vec_wdata_at_done", 32'(wd_dn), 32'(v.wd));
    tick();
  endtask

  int ev_cyc [8];
  int ev_who [8];
  int n_ev;
  int cnt_d0, cnt_d1;

  initial begin
    vecs[0] = '{0, 1'b0, 7'h50, 16'hA5C3, 16'h1111, 1, 21, 16'h0000, 16'h0000};
    vecs[1] = '{1, 1'b1, 7'h3C, 16'h0000, 16'hBEEF, 1, 21, 16'h0000, 16'hBEEF};
    vecs[2] = '{0, 1'b1, 7'h11, 16'h7777, 16'h1234, 1, 21, 16'h1234, 16'hBEEF};
    vecs[3] = '{1, 1'b0, 7'h22, 16'h5A5A, 16'hDEAD, 1, 21, 16'h1234, 16'hBEEF};
    vecs[4] = '{0, 1'b0, 7'h7F, 16'hFFFF, 16'h4321, 1, 21, 16'h1234, 16'hBEEF};

    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_addr", 32'(ic2_addr), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Contention then continuous round-robin: grants 0,1,0,1 every 22 cycles.
    do_reset();
    v0 = 1; rnw0 = 0; addr0 = 7'h01; wd0 = 16'h0101;
    v1 = 1; rnw1 = 0; addr1 = 7'h02; wd1 = 16'h0202;
    n_ev = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (n_ev < 8 && ready0 === 1'b1) begin ev_cyc[n_ev] = k; ev_who[n_ev] = 0; n_ev++; end
      if (n_ev < 8 && ready1 === 1'b1) begin ev_cyc[n_ev] = k; ev_who[n_ev] = 1; n_ev++; end
    end
    v0 = 0; v1 = 0;
    chk("rr_grants", 32'(n_ev), 32'd4);
    for (int i = 0; i < 4 && i < n_ev; i++) begin
      chk("rr_cyc", 32'(ev_cyc[i]), 32'(1 + 22 * i));
      chk("rr_who", 32'(ev_who[i]), 32'(i % 2));
    end
    for (int k = 0; k < 25; k++) tick();

    // Reset during WAIT of a read: no DONE, no RDATA update, normal restart.
    do_reset();
    v1 = 1; rnw1 = 1; addr1 = 7'h3C; rd_data = 16'hCAFE;
    tick(); v1 = 0;
    for (int k = 2; k <= 10; k++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_start", 32'(start), 32'd0);
    chk("abort_rdata1", 32'(rdata1), 32'd0);
    tick();
    v0 = 1; rnw0 = 0; addr0 = 7'h12; wd0 = 16'h1200;
    tick(); v0 = 0;
    chk("abort_new_ready", 32'(ready0), 32'd1);
    cnt_d0 = 0; cnt_d1 = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done0 === 1'b1) cnt_d0++;
      if (done1 === 1'b1) cnt_d1++;
    end
    chk("abort_done1_cnt", 32'(cnt_d1), 32'd0);
    chk("abort_done0_cnt", 32'(cnt_d0), 32'd1);
    chk("abort_rdata1_end", 32'(rdata1), 32'd0);

    // Field change after accept must not reach the bus.
    v0 = 1; rnw0 = 0; addr0 = 7'h50; wd0 = 16'hA5C3;
    tick(); v0 = 0;
    for (int k = 1; k <= 21; k++) begin
      if (k == 2) begin addr0 = 7'h51; wd0 = 16'h0000; end
      chk("hold_addr", 32'(ic2_addr), 32'h50);
      chk("hold_wdata", 32'(wr_data), 32'hA5C3);
      if (k < 21) tick();
    end
    chk("hold_done", 32'(done0), 32'd1);
    tick();

    // Randomized traffic with early drops, field noise and occasional reset.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      rd_data = 16'($urandom);
      if (v0 && e_ready0) v0 = 0;
      else if (v0 && $urandom_range(0, 39) == 0) v0 = 0;
      else if (!v0 && $urandom_range(0, 3) == 0) begin
        v0 = 1; rnw0 = 1'($urandom); addr0 = 7'($urandom); wd0 = 16'($urandom);
      end
      if (v1 && e_ready1) v1 = 0;
      else if (v1 && $urandom_range(0, 39) == 0) v1 = 0;
      else if (!v1 && $urandom_range(0, 3) == 0) begin
        v1 = 1; rnw1 = 1'($urandom); addr1 = 7'($urandom); wd1 = 16'($urandom);
      end
      if (!v0) begin addr0 = 7'($urandom); wd0 = 16'($urandom); end
      if (!v1) begin addr1 = 7'($urandom); wd1 = 16'($urandom); end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
